// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - data-memory request/acknowledge handshake between hazard controller and memory
interface pipeline_hazard_ctrl_if;
    logic dmem_req;
    logic dmem_ack;

    modport master (output dmem_req, input dmem_ack);
    modport slave  (input dmem_req, output dmem_ack);
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - five-stage pipeline stall/flush/freeze sequencer with memory timeout
// Optional STALL_COUNT_EN adds a saturating stall_cycles output.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int ZERO_REG    = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  IFID_Rn,
    input  logic [4:0]  IFID_Rm,
    input  logic        IFID_UsesRm,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_Rd,
    input  logic        EX_BranchTaken,
    input  logic        EXMEM_MemAccess,
    pipeline_hazard_ctrl_if.master dmem,
    output logic        pc_en,
    output logic        IFID_en,
    output logic        IDEX_en,
    output logic        EXMEM_en,
    output logic        MEMWB_en,
    output logic        IFID_flush,
    output logic        IDEX_bubble,
    output logic        MEMWB_bubble,
    output logic        err,
`ifdef STALL_COUNT_EN
    output logic [31:0] stall_cycles,
`endif
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_ERROR   = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);
    localparam logic [4:0] ZERO_C    = 5'(ZERO_REG);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       r_err;
    logic       w_err_next;
    logic       w_freeze;
    logic       w_advance;
    logic       w_load_use;

    assign w_load_use = IDEX_MemRead && (IDEX_Rd != ZERO_C) &&
                        ((IDEX_Rd == IFID_Rn) || (IFID_UsesRm && (IDEX_Rd == IFID_Rm)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_cnt_next    = r_cnt;
        w_err_next    = r_err;
        w_freeze      = 1'b0;
        w_advance     = 1'b0;
        pc_en         = 1'b1;
        IFID_en       = 1'b1;
        IDEX_en       = 1'b1;
        EXMEM_en      = 1'b1;
        MEMWB_en      = 1'b1;
        IFID_flush    = 1'b0;
        IDEX_bubble   = 1'b0;
        MEMWB_bubble  = 1'b0;
        dmem.dmem_req = 1'b0;

        if (reset) begin
            pc_en        = 1'b0;
            IFID_en      = 1'b0;
            IDEX_en      = 1'b0;
            EXMEM_en     = 1'b0;
            MEMWB_en     = 1'b0;
            IFID_flush   = 1'b1;
            IDEX_bubble  = 1'b1;
            MEMWB_bubble = 1'b1;
            w_next       = ST_RUN;
            w_cnt_next   = 8'd0;
            w_err_next   = 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    dmem.dmem_req = EXMEM_MemAccess;
                    if (EXMEM_MemAccess && !dmem.dmem_ack) begin
                        w_freeze   = 1'b1;
                        w_next     = ST_MEMWAIT;
                        w_cnt_next = 8'd1;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
                ST_MEMWAIT: begin
                    dmem.dmem_req = EXMEM_MemAccess;
                    if (!dmem.dmem_ack) begin
                        w_freeze = 1'b1;
                        if (r_cnt == TIMEOUT_C) begin
                            w_next     = ST_ERROR;
                            w_err_next = 1'b1;
                        end else begin
                            w_cnt_next = r_cnt + 8'd1;
                        end
                    end else begin
                        w_next     = ST_RUN;
                        w_cnt_next = 8'd0;
                        w_advance  = 1'b1;
                    end
                end
                ST_ERROR: begin
                    pc_en    = 1'b0;
                    IFID_en  = 1'b0;
                    IDEX_en  = 1'b0;
                    EXMEM_en = 1'b0;
                    MEMWB_en = 1'b0;
                end
                default: begin
                    w_next     = ST_RUN;
                    w_cnt_next = 8'd0;
                end
            endcase

            // Freeze lets only the MEMWB bubble through; flush/stall wait for the ack cycle.
            if (w_freeze) begin
                pc_en        = 1'b0;
                IFID_en      = 1'b0;
                IDEX_en      = 1'b0;
                EXMEM_en     = 1'b0;
                MEMWB_bubble = 1'b1;
            end else if (w_advance && EX_BranchTaken) begin
                IFID_flush  = 1'b1;
                IDEX_bubble = 1'b1;
            end else if (w_advance && w_load_use) begin
                pc_en       = 1'b0;
                IFID_en     = 1'b0;
                IDEX_bubble = 1'b1;
            end
        end
    end

    assign state = r_state;
    assign err   = r_err;

`ifdef STALL_COUNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
        end else if (!pc_en && (r_state == ST_RUN || r_state == ST_MEMWAIT) &&
                     (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed-vector self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    // ctrl vector: {pc,IFID,IDEX,EXMEM,MEMWB enables, IFID_flush, IDEX_bubble, MEMWB_bubble, dmem_req}
    localparam logic [8:0] C_IDLE   = 9'b11111_000_0;
    localparam logic [8:0] C_ACC    = 9'b11111_000_1;
    localparam logic [8:0] C_RESET  = 9'b00000_111_0;
    localparam logic [8:0] C_LDUSE  = 9'b00111_010_0;
    localparam logic [8:0] C_BRANCH = 9'b11111_110_0;
    localparam logic [8:0] C_FREEZE = 9'b00001_001_1;
    localparam logic [8:0] C_ACKBR  = 9'b11111_110_1;
    localparam logic [8:0] C_ERROR  = 9'b00000_000_0;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  IFID_Rn, IFID_Rm, IDEX_Rd;
    logic        IFID_UsesRm, IDEX_MemRead, EX_BranchTaken, EXMEM_MemAccess;
    logic        pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en;
    logic        IFID_flush, IDEX_bubble, MEMWB_bubble, err;
    logic [1:0]  state;
`ifdef STALL_COUNT_EN
    logic [31:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pipeline_hazard_ctrl_if u_if ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .ZERO_REG(31)) dut (
        .clk             (clk),
        .reset           (reset),
        .IFID_Rn         (IFID_Rn),
        .IFID_Rm         (IFID_Rm),
        .IFID_UsesRm     (IFID_UsesRm),
        .IDEX_MemRead    (IDEX_MemRead),
        .IDEX_Rd         (IDEX_Rd),
        .EX_BranchTaken  (EX_BranchTaken),
        .EXMEM_MemAccess (EXMEM_MemAccess),
        .dmem            (u_if),
        .pc_en           (pc_en),
        .IFID_en         (IFID_en),
        .IDEX_en         (IDEX_en),
        .EXMEM_en        (EXMEM_en),
        .MEMWB_en        (MEMWB_en),
        .IFID_flush      (IFID_flush),
        .IDEX_bubble     (IDEX_bubble),
        .MEMWB_bubble    (MEMWB_bubble),
        .err             (err),
`ifdef STALL_COUNT_EN
        .stall_cycles    (stall_cycles),
`endif
        .state           (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ctrl();
        return 32'({pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
                    IFID_flush, IDEX_bubble, MEMWB_bubble, u_if.dmem_req});
    endfunction

    task automatic clear_inputs();
        IFID_Rn = 5'd0; IFID_Rm = 5'd0; IFID_UsesRm = 1'b0;
        IDEX_MemRead = 1'b0; IDEX_Rd = 5'd0; EX_BranchTaken = 1'b0;
        EXMEM_MemAccess = 1'b0; u_if.dmem_ack = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(); reset = 1'b1; clear_inputs();
        cyc(); cyc(); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        cyc(); cyc(); cyc();
        reset = 1'b0; #1;
        check("post_reset_ctrl", ctrl(), 32'(C_IDLE));
        check("post_reset_state", 32'(state), 32'd0);
        check("post_reset_err", 32'(err), 32'd0);

        // Reset taken while in MEMWAIT
        cyc(); EXMEM_MemAccess = 1'b1; #1;
        check("enter_wait_ctrl", ctrl(), 32'(C_FREEZE));
        cyc(); #1;
        check("in_memwait_state", 32'(state), 32'd1);
        cyc(); reset = 1'b1; #1;
        check("reset_forced_ctrl", ctrl(), 32'(C_RESET));
        cyc(); cyc(); #1;
        check("reset_wait_state", 32'(state), 32'd0);
        check("reset_wait_err", 32'(err), 32'd0);
        check("reset_hold_ctrl", ctrl(), 32'(C_RESET));
        cyc(); reset = 1'b0; EXMEM_MemAccess = 1'b0; #1;
        check("release_ctrl", ctrl(), 32'(C_IDLE));

        // Load-use on Rn, then the bubble clears MemRead
        cyc(); IDEX_MemRead = 1'b1; IDEX_Rd = 5'd5; IFID_Rn = 5'd5; #1;
        check("lduse_rn_ctrl", ctrl(), 32'(C_LDUSE));
        cyc(); IDEX_MemRead = 1'b0; #1;
        check("lduse_after_ctrl", ctrl(), 32'(C_IDLE));
        cyc(); IDEX_MemRead = 1'b1; IDEX_Rd = 5'd31; IFID_Rn = 5'd31; #1;
        check("lduse_xzr_ctrl", ctrl(), 32'(C_IDLE));
        cyc(); IDEX_Rd = 5'd7; IFID_Rn = 5'd2; IFID_Rm = 5'd7; IFID_UsesRm = 1'b1; #1;
        check("lduse_rm_ctrl", ctrl(), 32'(C_LDUSE));
        cyc(); IFID_UsesRm = 1'b0; #1;
        check("lduse_rm_unused_ctrl", ctrl(), 32'(C_IDLE));

        // Branch beats load-use
        cyc(); IDEX_Rd = 5'd5; IFID_Rn = 5'd5; EX_BranchTaken = 1'b1; #1;
        check("branch_over_lduse_ctrl", ctrl(), 32'(C_BRANCH));

        // 3-cycle memory wait with a branch pending; ack on 4th cycle
        do_reset();
        EXMEM_MemAccess = 1'b1; EX_BranchTaken = 1'b1; #1;
        check("wait0_ctrl", ctrl(), 32'(C_FREEZE));
        check("wait0_state", 32'(state), 32'd0);
        for (int i = 1; i <= 2; i++) begin
            cyc(); #1;
            check($sformatf("wait%0d_ctrl", i), ctrl(), 32'(C_FREEZE));
            check($sformatf("wait%0d_state", i), 32'(state), 32'd1);
        end
        cyc(); u_if.dmem_ack = 1'b1; #1;
        check("ack_ctrl", ctrl(), 32'(C_ACKBR));
        check("ack_state", 32'(state), 32'd1);
        cyc(); u_if.dmem_ack = 1'b0; EXMEM_MemAccess = 1'b0; EX_BranchTaken = 1'b0; #1;
        check("after_ack_state", 32'(state), 32'd0);
        check("after_ack_ctrl", ctrl(), 32'(C_IDLE));
`ifdef STALL_COUNT_EN
        check("wait_stall_cycles", stall_cycles, 32'd3);
`endif

        // Zero-wait access
        cyc(); EXMEM_MemAccess = 1'b1; u_if.dmem_ack = 1'b1; #1;
        check("zero_wait_ctrl", ctrl(), 32'(C_ACC));
        cyc(); #1;
        check("zero_wait_state", 32'(state), 32'd0);

        // Timeout with MEM_TIMEOUT=4
        do_reset();
        EXMEM_MemAccess = 1'b1; #1;
        check("to_start_ctrl", ctrl(), 32'(C_FREEZE));
        for (int i = 1; i <= 4; i++) begin
            cyc(); #1;
            check($sformatf("to_wait%0d_state", i), 32'(state), 32'd1);
            check($sformatf("to_wait%0d_err", i), 32'(err), 32'd0);
        end
        cyc(); #1;
        check("to_error_state", 32'(state), 32'd2);
        check("to_error_err", 32'(err), 32'd1);
        check("to_error_ctrl", ctrl(), 32'(C_ERROR));
        cyc(); u_if.dmem_ack = 1'b1; #1;
        check("late_ack_ctrl", ctrl(), 32'(C_ERROR));
        cyc(); #1;
        check("late_ack_state", 32'(state), 32'd2);
        check("late_ack_err", 32'(err), 32'd1);
`ifdef STALL_COUNT_EN
        check("to_stall_cycles", stall_cycles, 32'd5);
`endif
        do_reset(); #1;
        check("final_state", 32'(state), 32'd0);
        check("final_err", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencing controller for the five-stage CPU. It drives the enable and bubble/flush controls of the PC and of the IFID, IDEX, EXMEM and MEMWB pipeline registers. It resolves three conditions:
- load-use hazards in decode,
- taken branches resolved in EX,
- variable-latency data-memory accesses in MEM.

For the memory case it runs a request/acknowledge handshake with data memory and enforces a timeout.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum MEMWAIT cycles before the ERROR state; legal range 1–255.
- ZERO_REG, 31: register index hardwired to zero (XZR); never a hazard source.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- IFID_Rn  in  5  first source register of the instruction in decode.
- IFID_Rm  in  5  second source register of the instruction in decode.
- IFID_UsesRm  in  1  the decode instruction reads Rm.
- IDEX_MemRead  in  1  the instruction in EX is a load.
- IDEX_Rd  in  5  destination register of the instruction in EX.
- EX_BranchTaken  in  1  a branch or BL resolved taken in EX this cycle.
- EXMEM_MemAccess  in  1  the instruction in MEM is a load or store.
- dmem_ack  in  1  data memory has completed the access this cycle.
- dmem_req  out  1  access request to data memory.
- pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en  out  1 each  pipeline register enables.
- IFID_flush  out  1  load a NOP into IFID.
- IDEX_bubble  out  1  load zeroed control signals into IDEX.
- MEMWB_bubble  out  1  load MEMWB with RegWrite=0.
- err  out  1  sticky memory-timeout error.
- state  out  2  FSM state: RUN=0, MEMWAIT=1, ERROR=2.

## Operation
FSM state, timeout counter (8 bits) and err are registered. All other outputs are combinational from state and inputs.

- **Reset** (reset=1, takes effect at the clock edge):
  - State → RUN; counter → 0; err → 0.
  - While reset is high, outputs are forced: all enables 0, IFID_flush=1, IDEX_bubble=1, MEMWB_bubble=1, dmem_req=0.
  - Reset has priority over every other input, including in MEMWAIT or ERROR.
- **RUN, default:** all enables 1, all bubble/flush signals 0.
- **dmem_req** = EXMEM_MemAccess while in RUN or MEMWAIT; 0 in ERROR.
- **RUN, memory access with dmem_ack=1 in the same cycle:** zero-wait access; no stall; remain in RUN.
- **RUN, memory access with dmem_ack=0:** freeze in the same cycle.
  - pc_en, IFID_en, IDEX_en and EXMEM_en are 0.
  - MEMWB_en=1 with MEMWB_bubble=1.
  - Next state MEMWAIT; counter ← 1.
- **MEMWAIT, dmem_ack=0:** freeze continues; counter increments.
- **MEMWAIT, dmem_ack=1:** all enables 1, MEMWB_bubble=0; next state RUN; counter ← 0.
- **Timeout:** in MEMWAIT with counter == MEM_TIMEOUT and dmem_ack=0 → next state ERROR; err ← 1.
- **ERROR:** all enables 0; dmem_req=0; held until reset.
- **Branch flush** (RUN and not freezing, EX_BranchTaken=1): IFID_flush=1 and IDEX_bubble=1; all enables 1.
- **Load-use stall** (RUN, not freezing, no taken branch): applies when IDEX_MemRead=1, IDEX_Rd≠ZERO_REG, and either IDEX_Rd==IFID_Rn, or IFID_UsesRm=1 and IDEX_Rd==IFID_Rm.
  - Outputs: pc_en=0, IFID_en=0, IDEX_bubble=1; IDEX_en, EXMEM_en and MEMWB_en are 1.
  - The stall lasts exactly one cycle because the bubble clears IDEX_MemRead.
- **Priority:** reset > ERROR > memory freeze > branch flush > load-use stall.
  - A freeze suppresses flushes and stalls; they are re-evaluated on the cycle dmem_ack arrives.

## Timing
- Zero-wait memory access: 0 stall cycles.
- N-cycle wait (ack arrives N cycles after the first request): exactly N freeze cycles; the pipeline advances on the ack cycle.
- Load-use: 1 stall cycle.
- Taken branch: 2 squashed instructions (IFID and IDEX), no stall cycle.
- ERROR is entered on the edge ending the MEM_TIMEOUT-th MEMWAIT cycle with no ack. err is visible the cycle after.
- The counter never wraps; MEM_TIMEOUT ≤ 255 guarantees this.

## Configuration
- **STALL_COUNT_EN defined:** adds output port `stall_cycles` (out, 32 bits).
  - Reset value 0.
  - Increments on every cycle in which pc_en=0 and the state is RUN or MEMWAIT.
  - Saturates at 0xFFFFFFFF.
- **STALL_COUNT_EN not defined:** the port and the counter do not exist; all other behaviour is identical.

## Test plan
- **Reset:** assert reset 2 cycles while in MEMWAIT → state=0, err=0, all enables 0, dmem_req=0. Release reset → all enables 1.
- **Load-use:** IDEX_MemRead=1, IDEX_Rd=5, IFID_Rn=5 → exactly 1 cycle of pc_en=0, IFID_en=0, IDEX_bubble=1. Repeat with IDEX_Rd=31 → no stall.
- **Branch beats load-use:** EX_BranchTaken=1 together with a load-use match → IFID_flush=1, IDEX_bubble=1, pc_en=1.
- **3-cycle memory wait:** EXMEM_MemAccess=1, dmem_ack asserted on the 4th cycle → 3 freeze cycles with MEMWB_bubble=1, state=1. Ack cycle: all enables 1, then state=0. With STALL_COUNT_EN, stall_cycles=3.
- **Timeout:** MEM_TIMEOUT=4, dmem_ack held 0 → state=2 and err=1 after 4 MEMWAIT cycles; dmem_req=0. A late dmem_ack has no effect until reset.
- **Zero-wait access:** EXMEM_MemAccess=1 with dmem_ack=1 in the same cycle → no freeze; state stays 0.
